register_read_port: RTL and testbench

Read-side companion to the design's 8-bit storage registers. It accepts read requests over a valid/ready handshake and looks up the addressed register from a flattened bus of register outputs. Results return through a 2-entry response FIFO with 1-cycle latency. A write issued in the same cycle as the read is forwarded to that read (bypass). The block sits between the register bank and any consumer (ALU operand fetch, debug readback) that needs back-pressured, ordered reads.

---
 rtl/register_read_port.sv | 106 ++++++++++
 tb/tb_register_read_port.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/register_read_port.sv
// Back-pressured read port for the register bank. Reads are looked up at
// acceptance (with same-edge write bypass) and queued in a 2-entry response FIFO.
module register_read_port #(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REGS*DATA_W-1:0] reg_values,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_addr,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       rsp_err
);

    localparam logic [ADDR_W:0] NumRegs = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W:0]   mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    logic              push, pop;
    logic              in_range;
    logic [DATA_W-1:0] reg_sel;
    logic [DATA_W:0]   new_entry;

    assign req_ready = rst && (count_q != 2'd2);
    assign rsp_valid = (count_q != 2'd0);
    assign push      = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign in_range  = {1'b0, req_addr} < NumRegs;

    always_comb begin
        reg_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (req_addr == ADDR_W'(i)) begin
                reg_sel = reg_values[i*DATA_W +: DATA_W];
            end
        end
    end

    // An equal in-range request address implies the write is in range too,
    // so out-of-range writes can never bypass.
    always_comb begin
        new_entry = '0;
        if (!in_range) begin
            new_entry = {1'b1, {DATA_W{1'b0}}};
        end else if (wr_en && (wr_addr == req_addr)) begin
            new_entry = {1'b0, wr_data};
        end else begin
            new_entry = {1'b0, reg_sel};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= new_entry;
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        rsp_err  = 1'b0;
        if (count_q != 2'd0) begin
            rsp_data = mem_q[rd_ptr_q][DATA_W-1:0];
            rsp_err  = mem_q[rd_ptr_q][DATA_W];
        end
    end

endmodule

// File: tb/tb_register_read_port.sv
// Directed bench for register_read_port with a queue scoreboard of expected
// {err,data} responses built from a model of the register bank.
module tb_register_read_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] reg_values;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;

    logic [7:0]  regs [8];
    logic [8:0]  sb [$];
    int          total  = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    register_read_port dut (
        .clk        (clk),
        .rst        (rst),
        .reg_values (reg_values),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic packRegs();
        for (int i = 0; i < 8; i++) reg_values[i*8 +: 8] = regs[i];
    endtask

    function automatic logic [8:0] modelRead(input logic [3:0] a);
        if (a >= 4'd8) return 9'h100;
        if (wr_en && wr_addr == a) return {1'b0, wr_data};
        return {1'b0, regs[a[2:0]]};
    endfunction

    // Checks outputs against the scoreboard, then advances one edge and
    // applies any write to the modelled register bank.
    task automatic tick();
        logic willPush, willPop;
        #1;
        check("req_ready", {31'b0, req_ready}, {31'b0, sb.size() != 2});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, sb.size() != 0});
        if (sb.size() == 0)
            check("rsp_empty", {23'b0, rsp_err, rsp_data}, 32'h0);
        else
            check("rsp_head", {23'b0, rsp_err, rsp_data}, {23'b0, sb[0]});
        willPush = req_valid && (sb.size() != 2);
        willPop  = rsp_ready && (sb.size() != 0);
        if (willPop) void'(sb.pop_front());
        if (willPush) sb.push_back(modelRead(req_addr));
        @(posedge clk);
        #1;
        if (wr_en && wr_addr < 4'd8) begin
            regs[wr_addr[2:0]] = wr_data;
            packRegs();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
        check({tag, "_rsp_data"},  {24'b0, rsp_data},  32'h0);
        check({tag, "_rsp_err"},   {31'b0, rsp_err},   32'h0);
        check({tag, "_req_ready"}, {31'b0, req_ready}, 32'h0);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 8'h10 + 8'(i);
        packRegs();
        #3;
        checkResetOutputs("reset_init");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Reset and fill: back-to-back reads of 3 and 7
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 4'd3; tick();
        req_addr = 4'd7; tick();
        req_valid = 1'b0; tick(); tick(); tick();

        // Bypass
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hAA; tick();
        req_valid = 1'b1; req_addr = 4'd5; wr_data = 8'h55; tick();
        req_valid = 1'b0; wr_data = 8'hAA; tick();
        req_valid = 1'b1; wr_addr = 4'd4; wr_data = 8'h44; tick();
        req_valid = 1'b0; wr_en = 1'b0; tick(); tick();

        // Out of range read and write
        req_valid = 1'b1; req_addr = 4'd9; tick();
        req_addr = 4'd1; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h99; tick();
        req_valid = 1'b0; wr_en = 1'b0; tick(); tick();

        // Back-pressure
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 4'd0; tick();
        req_addr = 4'd1; tick();
        req_addr = 4'd2; tick(); tick();
        rsp_ready = 1'b1; tick();
        rsp_ready = 1'b0; tick();
        req_valid = 1'b0; rsp_ready = 1'b1; tick(); tick(); tick();

        // Simultaneous push and pop at count 1
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'd7; tick();
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_addr = 4'(i % 8);
            tick();
            check("pp_count1", {31'b0, rsp_valid}, 32'h1);
        end
        req_valid = 1'b0; tick(); tick();

        // Async reset with a full FIFO
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'd2; tick();
        req_addr = 4'd3; tick();
        req_valid = 1'b0;
        check("full_before_reset", {31'b0, req_ready}, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        checkResetOutputs("reset_async");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 4'd6; tick();
        req_valid = 1'b0; tick(); tick();
        check("no_stale_entry", {31'b0, rsp_valid}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
